// File: rtl/conv_layer_controller_pkg.sv
// Shared state encoding, counter width and sizing helper for the convolution layer controller.
package conv_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // Number of complete KxK windows in one img_w x img_h frame.
  function automatic logic [CNT_W-1:0] expected_outputs(input int img_w, input int img_h, input int k);
    int n;
    n = (img_w - k + 1) * (img_h - k + 1);
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_layer_controller_if.sv
// Pixel-stream handshake and status bundle between the frame source and the conv layer controller.
interface conv_layer_controller_if;
  import conv_ctrl_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             window_valid;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid,
    input  in_ready, shift_en, window_valid, out_valid, out_count, busy, frame_done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, shift_en, window_valid, out_valid, out_count, busy, frame_done
  );

endinterface

// File: rtl/conv_layer_controller_valid_delay_line.sv
// Fixed-latency 1-bit delay chain that aligns window_valid with the mult-adder tree result.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic any_set
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  if (DEPTH == 1) begin : g_single
    assign chain_d = din;
  end else begin : g_chain
    assign chain_d = {chain_q[DEPTH-2:0], din};
  end

  // Chain register; reset empties the pipeline so an aborted frame leaves nothing in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign dout    = chain_q[DEPTH-1];
  assign any_set = |chain_q;

endmodule

// File: rtl/conv_layer_controller.sv
// Frame sequencer: accepts a raster pixel stream, flags full KxK windows and qualifies tree outputs.
module conv_layer_controller
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int MA_LATENCY  = 4
) (
  input logic                    clock,
  input logic                    reset,
  conv_layer_controller_if.slave ctrl
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(KERNEL_SIZE - 1);

  ctrl_state_e      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             window_valid_q, window_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             accept_s;
  logic             dl_out_s;
  logic             dl_any_s;

  assign accept_s = ctrl.in_valid && (state_q == ST_RUN);

  // State, position, window flag and output counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      out_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      out_count_q    <= out_count_d;
    end
  end

  // Next-state, raster position and window detection.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    window_valid_d = 1'b0;
    out_count_d    = out_count_q;
    if (dl_out_s) begin
      out_count_d = out_count_q + 16'd1;
    end else begin
      out_count_d = out_count_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (ctrl.start) begin
          state_d     = ST_RUN;
          col_d       = '0;
          row_d       = '0;
          out_count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          // Columns left of the kernel edge straddle the row wrap and never form a window.
          window_valid_d = (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!dl_any_s && !window_valid_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  valid_delay_line #(
    .DEPTH (MA_LATENCY)
  ) u_valid_delay (
    .clock   (clock),
    .reset   (reset),
    .din     (window_valid_q),
    .dout    (dl_out_s),
    .any_set (dl_any_s)
  );

  assign ctrl.in_ready     = (state_q == ST_RUN);
  assign ctrl.shift_en     = accept_s;
  assign ctrl.window_valid = window_valid_q;
  assign ctrl.out_valid    = dl_out_s;
  assign ctrl.out_count    = out_count_q;
  assign ctrl.busy         = (state_q != ST_IDLE);
  assign ctrl.frame_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_layer_controller.sv
// Scoreboard bench: a 6x6 instance checked every cycle against a timestamp model, plus a 3x3 instance.
module tb_conv_layer_controller;

  localparam int W6  = 6;
  localparam int K   = 3;
  localparam int LAT = 4;
  localparam int NPIX6 = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  conv_layer_controller_if if6 ();
  conv_layer_controller_if if3 ();

  conv_layer_controller #(
    .IMG_WIDTH(6), .IMG_HEIGHT(6), .KERNEL_SIZE(K), .MA_LATENCY(LAT)
  ) dut6 (
    .clock (clk),
    .reset (rst),
    .ctrl  (if6)
  );

  conv_layer_controller #(
    .IMG_WIDTH(3), .IMG_HEIGHT(3), .KERNEL_SIZE(K), .MA_LATENCY(LAT)
  ) dut3 (
    .clock (clk),
    .reset (rst),
    .ctrl  (if3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the 6x6 instance: expected event times pushed on accept, popped when due.
  int wv6_q[$];
  int ov6_q[$];
  int done_t = -1;
  bit m_run  = 1'b0;
  bit m_idle = 1'b1;
  int m_idx  = 0;
  int m_cnt  = 0;

  always @(negedge clk) begin : monitor6
    bit exp_wv, exp_ov, exp_done, acc;
    int col, row;
    exp_wv = (wv6_q.size() > 0) && (wv6_q[0] == cyc);
    if (exp_wv) void'(wv6_q.pop_front());
    exp_ov = (ov6_q.size() > 0) && (ov6_q[0] == cyc);
    if (exp_ov) void'(ov6_q.pop_front());
    exp_done = (done_t == cyc);
    acc = if6.in_valid && m_run;
    if (mon_en) begin
      n_total++;
      if (if6.in_ready !== m_run) $display("FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, if6.in_ready, m_run);
      else n_pass++;
      n_total++;
      if (if6.shift_en !== acc) $display("FAIL mon_shift_en cyc=%0d got=%b exp=%b", cyc, if6.shift_en, acc);
      else n_pass++;
      n_total++;
      if (if6.window_valid !== exp_wv) $display("FAIL mon_window_valid cyc=%0d got=%b exp=%b", cyc, if6.window_valid, exp_wv);
      else n_pass++;
      n_total++;
      if (if6.out_valid !== exp_ov) $display("FAIL mon_out_valid cyc=%0d got=%b exp=%b", cyc, if6.out_valid, exp_ov);
      else n_pass++;
      n_total++;
      if (if6.frame_done !== exp_done) $display("FAIL mon_frame_done cyc=%0d got=%b exp=%b", cyc, if6.frame_done, exp_done);
      else n_pass++;
      n_total++;
      if (if6.busy !== !m_idle) $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, if6.busy, !m_idle);
      else n_pass++;
      n_total++;
      if (if6.out_count !== 16'(m_cnt)) $display("FAIL mon_out_count cyc=%0d got=%0d exp=%0d", cyc, if6.out_count, m_cnt);
      else n_pass++;
    end
    if (rst) begin
      wv6_q.delete();
      ov6_q.delete();
      done_t = -1;
      m_run  = 1'b0;
      m_idle = 1'b1;
      m_cnt  = 0;
    end else begin
      if (exp_ov) m_cnt++;
      if (acc) begin
        col = m_idx % W6;
        row = m_idx / W6;
        if (col >= K - 1 && row >= K - 1) begin
          wv6_q.push_back(cyc + 1);
          ov6_q.push_back(cyc + 1 + LAT);
        end
        m_idx++;
        if (m_idx == NPIX6) begin
          m_run  = 1'b0;
          done_t = cyc + 3 + LAT;
        end
      end
      if (if6.start && m_idle) begin
        m_run  = 1'b1;
        m_idle = 1'b0;
        m_idx  = 0;
        m_cnt  = 0;
      end
      if (exp_done) m_idle = 1'b1;
    end
  end

  // Drives one 6x6 frame (optional start, stall pattern, mid-frame start or reset) and tallies outputs.
  task automatic run_frame(input bit do_start, input bit toggle, input int poke_at, input int rst_at,
                           output int n_out, output int n_done, output int n_bad);
    int acc;
    bit poked, stop, prev_stall;
    acc = 0; poked = 1'b0; stop = 1'b0; prev_stall = 1'b0;
    n_out = 0; n_done = 0; n_bad = 0;
    if (do_start) begin
      if6.start = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      if6.start = 1'b0;
    end
    for (int t = 0; t < 400 && !stop; t++) begin
      if6.in_valid = toggle ? ((t % 2) == 0) : 1'b1;
      if6.start    = (poke_at >= 0) && (acc == poke_at) && !poked;
      rst          = (rst_at >= 0) && (acc == rst_at);
      if (if6.start) poked = 1'b1;
      @(negedge clk);
      if (if6.shift_en && !if6.in_valid) n_bad++;
      if (if6.window_valid && prev_stall) n_bad++;
      prev_stall = !if6.in_valid;
      if (if6.shift_en) acc++;
      if (if6.out_valid) n_out++;
      if (if6.frame_done) begin
        n_done++;
        stop = 1'b1;
      end
      if (rst) stop = 1'b1;
      @(posedge clk); #1;
    end
    if6.in_valid = 1'b0;
    if6.start    = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    if6.start = 1'b0; if6.in_valid = 1'b0;
    if3.start = 1'b0; if3.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    if6.start = 1'b1;
    @(negedge clk);
    n_total++;
    if ({if6.in_ready, if6.shift_en, if6.window_valid, if6.out_valid, if6.busy, if6.frame_done} !== 6'b0)
      $display("FAIL reset_flags6 got=%b exp=000000", {if6.in_ready, if6.shift_en, if6.window_valid, if6.out_valid, if6.busy, if6.frame_done});
    else n_pass++;
    n_total++;
    if ({if3.in_ready, if3.window_valid, if3.out_valid, if3.busy, if3.frame_done} !== 5'b0 || if3.out_count !== 16'd0)
      $display("FAIL reset_flags3 got=%b cnt=%0d exp=00000 cnt=0", {if3.in_ready, if3.window_valid, if3.out_valid, if3.busy, if3.frame_done}, if3.out_count);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    if6.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (if6.busy !== 1'b0) $display("FAIL reset_start_ignored busy got=%b exp=0", if6.busy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    int n_out, n_done, n_bad;
    run_frame(1'b1, 1'b0, -1, -1, n_out, n_done, n_bad);
    n_total++;
    if (n_out !== 16) $display("FAIL cont_outputs got=%0d exp=16", n_out); else n_pass++;
    n_total++;
    if (n_done !== 1) $display("FAIL cont_frame_done got=%0d exp=1", n_done); else n_pass++;
    n_total++;
    if (if6.out_count !== 16'd16) $display("FAIL cont_out_count got=%0d exp=16", if6.out_count); else n_pass++;
    n_total++;
    if (wv6_q.size() + ov6_q.size() !== 0) $display("FAIL cont_sb_drained got=%0d exp=0", wv6_q.size() + ov6_q.size());
    else n_pass++;
  endtask

  task automatic test_stall_toggle();
    int n_out, n_done, n_bad;
    run_frame(1'b1, 1'b1, -1, -1, n_out, n_done, n_bad);
    n_total++;
    if (n_out !== 16) $display("FAIL stall_outputs got=%0d exp=16", n_out); else n_pass++;
    n_total++;
    if (n_bad !== 0) $display("FAIL stall_activity got=%0d exp=0", n_bad); else n_pass++;
    n_total++;
    if (n_done !== 1 || if6.out_count !== 16'd16) $display("FAIL stall_done got=%0d/%0d exp=1/16", n_done, if6.out_count);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int n_out, n_done, n_bad;
    run_frame(1'b1, 1'b0, 10, -1, n_out, n_done, n_bad);
    n_total++;
    if (n_out !== 16 || n_done !== 1) $display("FAIL start_ignored got=%0d/%0d exp=16/1", n_out, n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n_out, n_done, n_bad, n_late;
    run_frame(1'b1, 1'b0, -1, 20, n_out, n_done, n_bad);
    @(negedge clk);
    n_total++;
    if ({if6.in_ready, if6.shift_en, if6.window_valid, if6.out_valid, if6.busy, if6.frame_done} !== 6'b0 || if6.out_count !== 16'd0)
      $display("FAIL midrst_outputs got=%b cnt=%0d exp=000000 cnt=0", {if6.in_ready, if6.shift_en, if6.window_valid, if6.out_valid, if6.busy, if6.frame_done}, if6.out_count);
    else n_pass++;
    n_total++;
    if (n_done !== 0) $display("FAIL midrst_no_done got=%0d exp=0", n_done); else n_pass++;
    @(posedge clk); #1;
    n_late = 0;
    repeat (10) begin
      @(negedge clk);
      if (if6.frame_done || if6.out_valid) n_late++;
      @(posedge clk); #1;
    end
    n_total++;
    if (n_late !== 0) $display("FAIL midrst_quiet got=%0d exp=0", n_late); else n_pass++;
    run_frame(1'b1, 1'b0, -1, -1, n_out, n_done, n_bad);
    n_total++;
    if (n_out !== 16 || n_done !== 1) $display("FAIL midrst_rerun got=%0d/%0d exp=16/1", n_out, n_done);
    else n_pass++;
  endtask

  task automatic test_min_frame();
    int wv3_q[$];
    int ov3_q[$];
    int acc, n_wv, n_ov, n_done, t_exp;
    bit stop;
    acc = 0; n_wv = 0; n_ov = 0; n_done = 0; stop = 1'b0;
    if3.start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    if3.start = 1'b0;
    for (int t = 0; t < 100 && !stop; t++) begin
      if3.in_valid = 1'b1;
      @(negedge clk);
      if (if3.window_valid) begin
        n_wv++;
        t_exp = (wv3_q.size() > 0) ? wv3_q.pop_front() : -1;
        n_total++;
        if (t_exp !== cyc) $display("FAIL min_wv_time got=%0d exp=%0d", cyc, t_exp); else n_pass++;
      end
      if (if3.out_valid) begin
        n_ov++;
        t_exp = (ov3_q.size() > 0) ? ov3_q.pop_front() : -1;
        n_total++;
        if (t_exp !== cyc) $display("FAIL min_ov_time got=%0d exp=%0d", cyc, t_exp); else n_pass++;
      end
      if (if3.shift_en) begin
        if (acc == 8) begin
          wv3_q.push_back(cyc + 1);
          ov3_q.push_back(cyc + 1 + LAT);
        end
        acc++;
      end
      if (if3.frame_done) begin
        n_done++;
        stop = 1'b1;
      end
      @(posedge clk); #1;
    end
    if3.in_valid = 1'b0;
    n_total++;
    if (n_wv !== 1 || n_ov !== 1) $display("FAIL min_counts got=%0d/%0d exp=1/1", n_wv, n_ov); else n_pass++;
    n_total++;
    if (n_done !== 1 || if3.out_count !== 16'd1) $display("FAIL min_done got=%0d cnt=%0d exp=1 cnt=1", n_done, if3.out_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_out, n_done, n_bad;
    run_frame(1'b1, 1'b0, -1, -1, n_out, n_done, n_bad);
    if6.start = 1'b1;
    @(negedge clk);
    n_total++;
    if (if6.out_count !== 16'd16) $display("FAIL b2b_count_held got=%0d exp=16", if6.out_count); else n_pass++;
    @(posedge clk); #1;
    if6.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (if6.out_count !== 16'd0 || if6.busy !== 1'b1) $display("FAIL b2b_restart got=%0d/%b exp=0/1", if6.out_count, if6.busy);
    else n_pass++;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, -1, -1, n_out, n_done, n_bad);
    n_total++;
    if (n_out !== 16 || n_done !== 1 || if6.out_count !== 16'd16)
      $display("FAIL b2b_second got=%0d/%0d/%0d exp=16/1/16", n_out, n_done, if6.out_count);
    else n_pass++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_continuous();
    test_stall_toggle();
    test_start_ignored();
    test_reset_mid_frame();
    test_min_frame();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
